// File: rtl/regbank_2w2r_if.sv
// Write, hold-set and read-port bundle for the two-write/two-read register bank.
// The master side is issue/writeback/operand-fetch logic; the slave side is the bank.
interface regbank_2w2r_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
);
  logic             en;
  logic             wa_en;
  logic [AW-1:0]    wa_addr;
  logic [WIDTH-1:0] wa_data;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             hs_en;
  logic [AW-1:0]    hs_addr;
  logic [AW-1:0]    ra_addr;
  logic [WIDTH-1:0] ra_data;
  logic [AW-1:0]    rb_addr;
  logic [WIDTH-1:0] rb_data;
  logic [NREGS-1:0] hold_q;
  logic             conflict;
  logic [15:0]      conflict_cnt;

  modport master (
    output en, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           hs_en, hs_addr, ra_addr, rb_addr,
    input  ra_data, rb_data, hold_q, conflict, conflict_cnt
  );

  modport slave (
    input  en, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           hs_en, hs_addr, ra_addr, rb_addr,
    output ra_data, rb_data, hold_q, conflict, conflict_cnt
  );
endinterface

// File: rtl/regbank_2w2r.sv
// Two-write/two-read register bank with per-register pending (hold) bits,
// port-A-wins same-address arbitration, collision counter and optional bypass.
module regbank_2w2r #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int AW     = $clog2(NREGS),
  parameter bit BYPASS = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  regbank_2w2r_if.slave bus
);
  localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

  logic [WIDTH-1:0] regs_r    [NREGS];
  logic [WIDTH-1:0] regs_nx_s [NREGS];
  logic [NREGS-1:0] hold_r;
  logic [NREGS-1:0] hold_nx_s;
  logic             conflict_r;
  logic [15:0]      cnt_r;
  logic [15:0]      cnt_nx_s;
  logic             wa_ok_s;
  logic             wb_ok_s;
  logic             hs_ok_s;
  logic             coll_s;
  logic             wb_win_s;
  logic [WIDTH-1:0] sto_a_s;
  logic [WIDTH-1:0] sto_b_s;
  logic [WIDTH-1:0] ra_s;
  logic [WIDTH-1:0] rb_s;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W);
  endfunction

  // Qualify ports with the global enable and range; detect same-address collisions
  always_comb begin
    wa_ok_s  = bus.en && bus.wa_en && in_range(bus.wa_addr);
    wb_ok_s  = bus.en && bus.wb_en && in_range(bus.wb_addr);
    hs_ok_s  = bus.en && bus.hs_en && in_range(bus.hs_addr);
    coll_s   = wa_ok_s && wb_ok_s && (bus.wa_addr == bus.wb_addr);
    wb_win_s = wb_ok_s && !coll_s;
    cnt_nx_s = (coll_s && (cnt_r != 16'hFFFF)) ? (cnt_r + 16'd1) : cnt_r;
  end

  // Next register contents and hold bits; a losing port-B write still clears hold
  always_comb begin
    regs_nx_s = regs_r;
    hold_nx_s = hold_r;
    for (int i = 0; i < NREGS; i++) begin
      if (wa_ok_s && (bus.wa_addr == AW'(i))) begin
        regs_nx_s[i] = bus.wa_data;
      end else if (wb_win_s && (bus.wb_addr == AW'(i))) begin
        regs_nx_s[i] = bus.wb_data;
      end else begin
        regs_nx_s[i] = regs_r[i];
      end
      if (hs_ok_s && (bus.hs_addr == AW'(i))) begin
        hold_nx_s[i] = 1'b1;
      end else if ((wa_ok_s && (bus.wa_addr == AW'(i))) ||
                   (wb_ok_s && (bus.wb_addr == AW'(i)))) begin
        hold_nx_s[i] = 1'b0;
      end else begin
        hold_nx_s[i] = hold_r[i];
      end
    end
  end

  // Read muxes: out-of-range indices match no register and read as zero
  always_comb begin
    sto_a_s = '0;
    sto_b_s = '0;
    for (int i = 0; i < NREGS; i++) begin
      sto_a_s = (bus.ra_addr == AW'(i)) ? regs_r[i] : sto_a_s;
      sto_b_s = (bus.rb_addr == AW'(i)) ? regs_r[i] : sto_b_s;
    end
    if (BYPASS && wa_ok_s && (bus.wa_addr == bus.ra_addr)) begin
      ra_s = bus.wa_data;
    end else if (BYPASS && wb_ok_s && (bus.wb_addr == bus.ra_addr)) begin
      ra_s = bus.wb_data;
    end else begin
      ra_s = sto_a_s;
    end
    if (BYPASS && wa_ok_s && (bus.wa_addr == bus.rb_addr)) begin
      rb_s = bus.wa_data;
    end else if (BYPASS && wb_ok_s && (bus.wb_addr == bus.rb_addr)) begin
      rb_s = bus.wb_data;
    end else begin
      rb_s = sto_b_s;
    end
  end

  // State registers; coll_s is already gated by en, so conflict drops when disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
      hold_r     <= '0;
      conflict_r <= 1'b0;
      cnt_r      <= 16'h0000;
    end else begin
      regs_r     <= regs_nx_s;
      hold_r     <= hold_nx_s;
      conflict_r <= coll_s;
      cnt_r      <= cnt_nx_s;
    end
  end

  assign bus.ra_data      = ra_s;
  assign bus.rb_data      = rb_s;
  assign bus.hold_q       = hold_r;
  assign bus.conflict     = conflict_r;
  assign bus.conflict_cnt = cnt_r;
endmodule

// File: tb/tb_regbank_2w2r.sv
// Directed bench for regbank_2w2r: a vector table on a 16-entry bypassing bank,
// plus hand sequences for reset, out-of-range handling (12 entries, no bypass) and saturation.
module tb_regbank_2w2r;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  regbank_2w2r_if #(.WIDTH(32), .NREGS(16)) bus ();
  regbank_2w2r_if #(.WIDTH(32), .NREGS(12)) bus2 ();

  regbank_2w2r #(.WIDTH(32), .NREGS(16), .BYPASS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  regbank_2w2r #(.WIDTH(32), .NREGS(12), .BYPASS(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        wa_en;
    logic [3:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        hs_en;
    logic [3:0]  hs_addr;
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;
    logic [31:0] exp_ra;
    logic [31:0] exp_rb;
    logic        exp_conf;
    logic [15:0] exp_hold;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic idle_bus();
    bus.en = 1'b1; bus.wa_en = 1'b0; bus.wa_addr = 4'd0; bus.wa_data = 32'h0;
    bus.wb_en = 1'b0; bus.wb_addr = 4'd0; bus.wb_data = 32'h0;
    bus.hs_en = 1'b0; bus.hs_addr = 4'd0; bus.ra_addr = 4'd0; bus.rb_addr = 4'd0;
  endtask

  task automatic idle_bus2();
    bus2.en = 1'b0; bus2.wa_en = 1'b0; bus2.wa_addr = 4'd0; bus2.wa_data = 32'h0;
    bus2.wb_en = 1'b0; bus2.wb_addr = 4'd0; bus2.wb_data = 32'h0;
    bus2.hs_en = 1'b0; bus2.hs_addr = 4'd0; bus2.ra_addr = 4'd0; bus2.rb_addr = 4'd0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // en wa_en wa_addr wa_data wb_en wb_addr wb_data hs_en hs_addr ra rb | exp_ra exp_rb conf hold cnt
    vt[0]  = '{1'b1, 1'b1, 4'd2, 32'h11111111, 1'b1, 4'd5, 32'h22222222, 1'b0, 4'd0, 4'd2, 4'd5,
               32'h11111111, 32'h22222222, 1'b0, 16'h0000, 16'h0000};
    vt[1]  = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd2, 4'd5,
               32'h11111111, 32'h22222222, 1'b0, 16'h0000, 16'h0000};
    vt[2]  = '{1'b1, 1'b1, 4'd7, 32'hAAAA0000, 1'b1, 4'd7, 32'h0000BBBB, 1'b0, 4'd0, 4'd7, 4'd7,
               32'hAAAA0000, 32'hAAAA0000, 1'b1, 16'h0000, 16'h0001};
    vt[3]  = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd2,
               32'hAAAA0000, 32'h11111111, 1'b0, 16'h0000, 16'h0001};
    vt[4]  = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 4'd4, 4'd0,
               32'h0, 32'h0, 1'b0, 16'h0010, 16'h0001};
    vt[5]  = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 32'h44444444, 1'b1, 4'd4, 4'd4, 4'd4,
               32'h44444444, 32'h44444444, 1'b0, 16'h0010, 16'h0001};
    vt[6]  = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 32'h00000055, 1'b1, 4'd1, 4'd4, 4'd9,
               32'h00000055, 32'h0, 1'b0, 16'h0002, 16'h0001};
    vt[7]  = '{1'b1, 1'b1, 4'd9, 32'h12345678, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd9, 4'd4,
               32'h12345678, 32'h00000055, 1'b0, 16'h0002, 16'h0001};
    vt[8]  = '{1'b0, 1'b1, 4'd9, 32'hCAFEF00D, 1'b1, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd6, 4'd9, 4'd5,
               32'h12345678, 32'h22222222, 1'b0, 16'h0002, 16'h0001};
    vt[9]  = '{1'b0, 1'b1, 4'd1, 32'h00000001, 1'b1, 4'd1, 32'h00000002, 1'b0, 4'd0, 4'd1, 4'd7,
               32'h0, 32'hAAAA0000, 1'b0, 16'h0002, 16'h0001};
    vt[10] = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd9, 4'd5,
               32'h12345678, 32'h22222222, 1'b0, 16'h0002, 16'h0001};
    vt[11] = '{1'b1, 1'b1, 4'd0, 32'h000000A0, 1'b1, 4'd1, 32'h000000B1, 1'b0, 4'd0, 4'd0, 4'd1,
               32'h000000A0, 32'h000000B1, 1'b0, 16'h0000, 16'h0001};
    vt[12] = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd1, 4'd0,
               32'h000000B1, 32'h000000A0, 1'b0, 16'h0000, 16'h0001};

    reset_n = 1'b0;
    idle_bus();
    idle_bus2();
    #12 reset_n = 1'b1;

    // Collision plus hold-set on r3, then a reset pulse between edges
    @(negedge clk);
    bus.wa_en = 1'b1; bus.wa_addr = 4'd3; bus.wa_data = 32'hDEADBEEF;
    bus.wb_en = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 32'h0BADF00D;
    bus.hs_en = 1'b1; bus.hs_addr = 4'd3;
    @(posedge clk); #1;
    chk("pre-reset conflict", {31'h0, bus.conflict}, 32'h1);
    chk("pre-reset cnt", {16'h0, bus.conflict_cnt}, 32'h1);
    chk("pre-reset hold", {16'h0, bus.hold_q}, 32'h0008);
    bus.wa_en = 1'b0; bus.wb_en = 1'b0; bus.hs_en = 1'b0; bus.ra_addr = 4'd3;
    #1;
    chk("pre-reset r3", bus.ra_data, 32'hDEADBEEF);
    reset_n = 1'b0;
    bus.wa_en = 1'b1; bus.wa_addr = 4'd3; bus.wa_data = 32'hDEADBEEF; bus.rb_addr = 4'd3;
    bus.ra_addr = 4'd4;
    #1;
    chk("reset r4", bus.ra_data, 32'h0);
    chk("reset hold", {16'h0, bus.hold_q}, 32'h0);
    chk("reset cnt", {16'h0, bus.conflict_cnt}, 32'h0);
    chk("reset conflict", {31'h0, bus.conflict}, 32'h0);
    bus.wa_en = 1'b0;
    #0.5;
    chk("reset r3", bus.rb_data, 32'h0);
    reset_n = 1'b1;

    // Table-driven vectors on the bypassing 16-entry bank
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      bus.en = vt[k].en; bus.wa_en = vt[k].wa_en; bus.wa_addr = vt[k].wa_addr;
      bus.wa_data = vt[k].wa_data; bus.wb_en = vt[k].wb_en; bus.wb_addr = vt[k].wb_addr;
      bus.wb_data = vt[k].wb_data; bus.hs_en = vt[k].hs_en; bus.hs_addr = vt[k].hs_addr;
      bus.ra_addr = vt[k].ra_addr; bus.rb_addr = vt[k].rb_addr;
      #1;
      chk($sformatf("v%0d ra_data", k), bus.ra_data, vt[k].exp_ra);
      chk($sformatf("v%0d rb_data", k), bus.rb_data, vt[k].exp_rb);
      @(posedge clk); #1;
      chk($sformatf("v%0d conflict", k), {31'h0, bus.conflict}, {31'h0, vt[k].exp_conf});
      chk($sformatf("v%0d hold_q", k), {16'h0, bus.hold_q}, {16'h0, vt[k].exp_hold});
      chk($sformatf("v%0d conflict_cnt", k), {16'h0, bus.conflict_cnt}, {16'h0, vt[k].exp_cnt});
    end

    // 12-entry bank without bypass: out-of-range writes, sets and reads
    @(negedge clk);
    idle_bus();
    bus2.en = 1'b1;
    bus2.wa_en = 1'b1; bus2.wa_addr = 4'd3; bus2.wa_data = 32'h00000033;
    bus2.wb_en = 1'b1; bus2.wb_addr = 4'd13; bus2.wb_data = 32'h000000DD;
    bus2.hs_en = 1'b1; bus2.hs_addr = 4'd13;
    bus2.ra_addr = 4'd3; bus2.rb_addr = 4'd13;
    #1;
    chk("nobyp ra same cycle", bus2.ra_data, 32'h0);
    chk("oor rb same cycle", bus2.rb_data, 32'h0);
    @(posedge clk); #1;
    chk("oor hold after set", {20'h0, bus2.hold_q}, 32'h0);
    chk("oor conflict 1", {31'h0, bus2.conflict}, 32'h0);
    @(negedge clk);
    bus2.wa_addr = 4'd13; bus2.wa_data = 32'h00000001;
    bus2.wb_addr = 4'd13; bus2.wb_data = 32'h00000002;
    bus2.hs_addr = 4'd11;
    #1;
    chk("nobyp ra stored", bus2.ra_data, 32'h00000033);
    chk("oor rb stored", bus2.rb_data, 32'h0);
    @(posedge clk); #1;
    chk("oor collision conflict", {31'h0, bus2.conflict}, 32'h0);
    chk("oor collision cnt", {16'h0, bus2.conflict_cnt}, 32'h0);
    chk("in-range hold set", {20'h0, bus2.hold_q}, 32'h00000800);
    @(negedge clk);
    idle_bus2();

    // Saturation: count 1 -> 0xFFFE, then three more back-to-back collisions
    bus.wa_en = 1'b1; bus.wa_addr = 4'd7; bus.wa_data = 32'h5A5A5A5A;
    bus.wb_en = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 32'hA5A5A5A5;
    repeat (65533) @(posedge clk);
    #1;
    chk("preload cnt", {16'h0, bus.conflict_cnt}, 32'h0000FFFE);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat%0d conflict", k), {31'h0, bus.conflict}, 32'h1);
      chk($sformatf("sat%0d cnt", k), {16'h0, bus.conflict_cnt}, 32'h0000FFFF);
    end
    @(negedge clk);
    idle_bus();
    bus.ra_addr = 4'd7;
    @(posedge clk); #1;
    chk("post-sat conflict", {31'h0, bus.conflict}, 32'h0);
    chk("post-sat cnt", {16'h0, bus.conflict_cnt}, 32'h0000FFFF);
    chk("post-sat r7", bus.ra_data, 32'h5A5A5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
